// File: rtl/qconv_tile_scheduler.sv
// ============================================================================
// qconv_tile_scheduler
//
// Sequences the tiled kn2row quantized-convolution datapath. A layer is walked
// as output-channel groups (outermost), tile rows, then tile columns
// (innermost). Every tile runs four phases in order, each started with a
// one-cycle go pulse and finished by a done pulse from the phase unit:
//   READ_INPUT -> READ_KERNEL -> CALC_MAC -> WRITE_OUTPUT
// READ_KERNEL is skipped while the kernel group already loaded is current.
//
// Ports
//   clk         clock
//   rstn        synchronous active-low reset
//   start       begin a layer (sampled only while idle)
//   out_h/w/c   layer output height / width / channels, latched on start
//   busy        high from the cycle after an accepted start through DONE
//   done        one-cycle pulse at the end of a layer
//   phase_go    one-hot go pulse: bit0 RD_IN, bit1 RD_K, bit2 MAC, bit3 WR
//   phase_done  per-phase completion pulses from the phase units
//   tile_row    tile origin row
//   tile_col    tile origin column
//   oc_base     first output channel of the current group
//   tile_vh     valid rows     = min(TILE_H, out_h - tile_row)
//   tile_vw     valid columns  = min(TILE_W, out_w - tile_col)
//   oc_valid    valid channels = min(OC_UNROLL, out_c - oc_base)
// ============================================================================
module qconv_tile_scheduler #(
    parameter int DIM_WIDTH = 32,
    parameter int TILE_H    = 32,
    parameter int TILE_W    = 32,
    parameter int OC_UNROLL = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [DIM_WIDTH-1:0] out_h,
    input  logic [DIM_WIDTH-1:0] out_w,
    input  logic [DIM_WIDTH-1:0] out_c,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           phase_go,
    input  logic [3:0]           phase_done,
    output logic [DIM_WIDTH-1:0] tile_row,
    output logic [DIM_WIDTH-1:0] tile_col,
    output logic [DIM_WIDTH-1:0] oc_base,
    output logic [DIM_WIDTH-1:0] tile_vh,
    output logic [DIM_WIDTH-1:0] tile_vw,
    output logic [DIM_WIDTH-1:0] oc_valid
);

    // One extra bit so origin + step never wraps when compared to a dimension
    // close to the top of the DIM_WIDTH range.
    localparam int W1 = DIM_WIDTH + 1;

    localparam logic [W1-1:0] STEP_H = W1'(TILE_H);
    localparam logic [W1-1:0] STEP_W = W1'(TILE_W);
    localparam logic [W1-1:0] STEP_C = W1'(OC_UNROLL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_IN,
        S_RD_K,
        S_MAC,
        S_WR,
        S_ADV,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 fresh_q, fresh_d;   // first cycle of a phase state
    logic                 kernel_q, kernel_d; // kernel of current group loaded
    logic [DIM_WIDTH-1:0] cfg_h_q, cfg_h_d;
    logic [DIM_WIDTH-1:0] cfg_w_q, cfg_w_d;
    logic [DIM_WIDTH-1:0] cfg_c_q, cfg_c_d;
    logic [DIM_WIDTH-1:0] row_q, row_d;
    logic [DIM_WIDTH-1:0] col_q, col_d;
    logic [DIM_WIDTH-1:0] oc_q, oc_d;
    logic [DIM_WIDTH-1:0] vh_q, vh_d;
    logic [DIM_WIDTH-1:0] vw_q, vw_d;
    logic [DIM_WIDTH-1:0] ov_q, ov_d;
    logic                 ext_upd;

    logic [3:0]           phase_sel;
    logic                 accept;
    logic [W1-1:0]        col_n, row_n, oc_n;

    // Remaining extent from an origin, clamped to the tile step.
    function automatic logic [DIM_WIDTH-1:0] extent(
        input logic [W1-1:0]        lim,
        input logic [DIM_WIDTH-1:0] dim,
        input logic [DIM_WIDTH-1:0] org
    );
        logic [W1-1:0] rem;
        rem = {1'b0, dim} - {1'b0, org};
        return (rem < lim) ? rem[DIM_WIDTH-1:0] : lim[DIM_WIDTH-1:0];
    endfunction

    // Candidate next origins, evaluated at full width.
    assign col_n = {1'b0, col_q} + STEP_W;
    assign row_n = {1'b0, row_q} + STEP_H;
    assign oc_n  = {1'b0, oc_q}  + STEP_C;

    // Which phase_done bit belongs to the active state.
    always_comb begin
        phase_sel = 4'b0000;
        case (state_q)
            S_RD_IN: phase_sel = 4'b0001;
            S_RD_K:  phase_sel = 4'b0010;
            S_MAC:   phase_sel = 4'b0100;
            S_WR:    phase_sel = 4'b1000;
            default: phase_sel = 4'b0000;
        endcase
    end

    // A done arriving in the go cycle itself belongs to no request yet.
    assign accept = !fresh_q && |(phase_done & phase_sel);

    // NOTE: every variable written here gets a default first, so no path
    // leaves a value held and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        kernel_d = kernel_q;
        cfg_h_d  = cfg_h_q;
        cfg_w_d  = cfg_w_q;
        cfg_c_d  = cfg_c_q;
        row_d    = row_q;
        col_d    = col_q;
        oc_d     = oc_q;
        ext_upd  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_h_d  = out_h;
                    cfg_w_d  = out_w;
                    cfg_c_d  = out_c;
                    // A new layer restarts at group 0, which is never the
                    // group left in the kernel buffer by a previous layer.
                    kernel_d = 1'b0;
                    if (out_h == '0 || out_w == '0 || out_c == '0) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = '0;
                        col_d   = '0;
                        oc_d    = '0;
                        ext_upd = 1'b1;
                        state_d = S_RD_IN;
                    end
                end
            end
            S_RD_IN: begin
                if (accept) state_d = kernel_q ? S_MAC : S_RD_K;
            end
            S_RD_K: begin
                if (accept) begin
                    state_d  = S_MAC;
                    kernel_d = 1'b1;
                end
            end
            S_MAC: begin
                if (accept) state_d = S_WR;
            end
            S_WR: begin
                if (accept) state_d = S_ADV;
            end
            S_ADV: begin
                state_d = S_RD_IN;
                ext_upd = 1'b1;
                if (col_n < {1'b0, cfg_w_q}) begin
                    col_d = col_n[DIM_WIDTH-1:0];
                end else if (row_n < {1'b0, cfg_h_q}) begin
                    col_d = '0;
                    row_d = row_n[DIM_WIDTH-1:0];
                end else if (oc_n < {1'b0, cfg_c_q}) begin
                    col_d    = '0;
                    row_d    = '0;
                    oc_d     = oc_n[DIM_WIDTH-1:0];
                    kernel_d = 1'b0;
                end else begin
                    // Layer finished: origins and extents keep their last
                    // values so they never read as zero while busy.
                    state_d = S_DONE;
                    ext_upd = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        vh_d = ext_upd ? extent(STEP_H, cfg_h_d, row_d) : vh_q;
        vw_d = ext_upd ? extent(STEP_W, cfg_w_d, col_d) : vw_q;
        ov_d = ext_upd ? extent(STEP_C, cfg_c_d, oc_d)  : ov_q;

        fresh_d = (state_d != state_q) &&
                  (state_d inside {S_RD_IN, S_RD_K, S_MAC, S_WR});
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge, independent of order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            fresh_q  <= 1'b0;
            kernel_q <= 1'b0;
            cfg_h_q  <= '0;
            cfg_w_q  <= '0;
            cfg_c_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            oc_q     <= '0;
            vh_q     <= '0;
            vw_q     <= '0;
            ov_q     <= '0;
        end else begin
            state_q  <= state_d;
            fresh_q  <= fresh_d;
            kernel_q <= kernel_d;
            cfg_h_q  <= cfg_h_d;
            cfg_w_q  <= cfg_w_d;
            cfg_c_q  <= cfg_c_d;
            row_q    <= row_d;
            col_q    <= col_d;
            oc_q     <= oc_d;
            vh_q     <= vh_d;
            vw_q     <= vw_d;
            ov_q     <= ov_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign phase_go = fresh_q ? phase_sel : 4'b0000;
    assign tile_row = row_q;
    assign tile_col = col_q;
    assign oc_base  = oc_q;
    assign tile_vh  = vh_q;
    assign tile_vw  = vw_q;
    assign oc_valid = ov_q;

endmodule

// File: tb/tb_qconv_tile_scheduler.sv
// ============================================================================
// tb_qconv_tile_scheduler
//
// Scoreboard bench. Stimulus pushes the expected tile sequence into a queue
// before starting a layer; a monitor pops one entry per READ_INPUT go and
// compares origin and extents, and re-checks the origin at MAC/WR go.
// A second, 8-bit-wide instance exercises origins near the top of the range.
// ============================================================================
module tb_qconv_tile_scheduler;

    localparam int DW = 32;
    localparam int BW = 8;

    typedef struct packed {
        logic [31:0] oc;
        logic [31:0] row;
        logic [31:0] col;
        logic [31:0] vh;
        logic [31:0] vw;
        logic [31:0] ov;
    } tile_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic          rstn, start, busy, done;
    logic [DW-1:0] out_h, out_w, out_c;
    logic [3:0]    phase_go, phase_done, man_pd, resp_pd;
    logic [DW-1:0] tile_row, tile_col, oc_base, tile_vh, tile_vw, oc_valid;

    // Narrow instance
    logic          b_start, b_busy, b_done;
    logic [BW-1:0] b_out_h, b_out_w, b_out_c;
    logic [3:0]    b_phase_go, b_phase_done;
    logic [BW-1:0] b_tile_row, b_tile_col, b_oc_base, b_tile_vh, b_tile_vw, b_oc_valid;

    assign phase_done = man_pd | resp_pd;

    qconv_tile_scheduler dut (
        .clk(clk), .rstn(rstn), .start(start),
        .out_h(out_h), .out_w(out_w), .out_c(out_c),
        .busy(busy), .done(done),
        .phase_go(phase_go), .phase_done(phase_done),
        .tile_row(tile_row), .tile_col(tile_col), .oc_base(oc_base),
        .tile_vh(tile_vh), .tile_vw(tile_vw), .oc_valid(oc_valid)
    );

    qconv_tile_scheduler #(.DIM_WIDTH(BW), .TILE_H(32), .TILE_W(32), .OC_UNROLL(8)) dut_narrow (
        .clk(clk), .rstn(rstn), .start(b_start),
        .out_h(b_out_h), .out_w(b_out_w), .out_c(b_out_c),
        .busy(b_busy), .done(b_done),
        .phase_go(b_phase_go), .phase_done(b_phase_done),
        .tile_row(b_tile_row), .tile_col(b_tile_col), .oc_base(b_oc_base),
        .tile_vh(b_tile_vh), .tile_vw(b_tile_vw), .oc_valid(b_oc_valid)
    );

    int    total = 0;
    int    bad   = 0;
    tile_t sb_q[$];
    tile_t sb2_q[$];
    tile_t cur;
    int    rdk_cnt = 0, done_cnt = 0, go_cnt = 0;
    int    b_rdk_cnt = 0, b_done_cnt = 0;
    bit    resp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int oc, input int row, input int col, input int vh, input int vw, input int ov);
        tile_t t;
        t = '{oc: oc, row: row, col: col, vh: vh, vw: vw, ov: ov};
        sb_q.push_back(t);
    endtask

    task automatic push2(input int oc, input int row, input int col, input int vh, input int vw, input int ov);
        tile_t t;
        t = '{oc: oc, row: row, col: col, vh: vh, vw: vw, ov: ov};
        sb2_q.push_back(t);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (phase_go[0]) begin
            if (sb_q.size() == 0) begin
                check("sb_extra_tile", 64'(sb_q.size()), 1);
            end else begin
                cur = sb_q.pop_front();
                check("tile_oc",  oc_base,  cur.oc);
                check("tile_row", tile_row, cur.row);
                check("tile_col", tile_col, cur.col);
                check("tile_vh",  tile_vh,  cur.vh);
                check("tile_vw",  tile_vw,  cur.vw);
                check("oc_valid", oc_valid, cur.ov);
            end
        end
        if (phase_go[2] || phase_go[3]) begin
            check("stable_origin", {tile_row, tile_col}, {cur.row, cur.col});
            check("stable_ext", {oc_base, tile_vh}, {cur.oc, cur.vh});
        end
        if (phase_go[1]) rdk_cnt++;
        if (|phase_go)   go_cnt++;
        if (done)        done_cnt++;
    end

    always @(negedge clk) begin
        if (b_phase_go[0]) begin
            if (sb2_q.size() == 0) begin
                check("sb2_extra_tile", 64'(sb2_q.size()), 1);
            end else begin
                tile_t t;
                t = sb2_q.pop_front();
                check("n_tile_oc",  b_oc_base,  t.oc);
                check("n_tile_row", b_tile_row, t.row);
                check("n_tile_col", b_tile_col, t.col);
                check("n_tile_vh",  b_tile_vh,  t.vh);
                check("n_tile_vw",  b_tile_vw,  t.vw);
                check("n_oc_valid", b_oc_valid, t.ov);
            end
        end
        if (b_phase_go[1]) b_rdk_cnt++;
        if (b_done)        b_done_cnt++;
    end

    // ---------------- phase responders ----------------
    initial begin
        logic [3:0] bits;
        resp_pd = 4'b0000;
        forever begin
            @(negedge clk);
            if (resp_en && |phase_go) begin
                bits = phase_go;
                repeat (3) @(posedge clk);
                #1 resp_pd = bits;
                @(posedge clk);
                #1 resp_pd = 4'b0000;
            end
        end
    end

    initial begin
        logic [3:0] bits;
        b_phase_done = 4'b0000;
        forever begin
            @(negedge clk);
            if (|b_phase_go) begin
                bits = b_phase_go;
                @(posedge clk);
                #1 b_phase_done = bits;
                @(posedge clk);
                #1 b_phase_done = 4'b0000;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start on cycle T; returns inside T+1, config then scrambled.
    task automatic start_layer(input logic [DW-1:0] h, input logic [DW-1:0] w, input logic [DW-1:0] c);
        step();
        out_h = h; out_w = w; out_c = c; start = 1'b1;
        step();
        start = 1'b0;
        out_h = 32'hDEAD; out_w = 32'h5; out_c = 32'h3;
    endtask

    // Drive a done pulse for one cycle; returns at the negedge after it.
    task automatic pulse(input logic [3:0] b);
        step();
        man_pd = b;
        step();
        man_pd = 4'b0000;
        @(negedge clk);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_timeout"}, 64'(seen), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_go"}, phase_go, 0);
        check({name, "_origin"}, {tile_row, tile_col}, 0);
        check({name, "_oc"}, oc_base, 0);
        check({name, "_ext"}, {tile_vh, tile_vw}, 0);
        check({name, "_ocv"}, oc_valid, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int r0, d0, g0;
        bit seen;
        rstn = 1'b0; start = 1'b0; out_h = '0; out_w = '0; out_c = '0; man_pd = 4'b0000;
        b_start = 1'b0; b_out_h = '0; b_out_w = '0; b_out_c = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        check("reset_narrow_busy", b_busy, 0);
        step();
        rstn = 1'b1;

        // Basic walk: 64x48x16
        resp_en = 1'b1;
        for (int oc = 0; oc < 16; oc += 8)
            for (int r = 0; r < 64; r += 32)
                for (int c = 0; c < 48; c += 32)
                    push(oc, r, c, 32, (c == 32) ? 16 : 32, 8);
        r0 = rdk_cnt; d0 = done_cnt;
        start_layer(64, 48, 16);
        wait_done("basic", 3000);
        check("basic_rdk_count", rdk_cnt - r0, 2);
        check("basic_done_count", done_cnt - d0, 1);
        check("basic_sb_left", sb_q.size(), 0);
        check("basic_idle", busy, 0);

        // Partial edges: 40x33x12
        for (int oc = 0; oc < 12; oc += 8)
            for (int r = 0; r < 40; r += 32)
                for (int c = 0; c < 33; c += 32)
                    push(oc, r, c, (r == 32) ? 8 : 32, (c == 32) ? 1 : 32, (oc == 8) ? 4 : 8);
        r0 = rdk_cnt; d0 = done_cnt;
        start_layer(40, 33, 12);
        wait_done("partial", 3000);
        check("partial_rdk_count", rdk_cnt - r0, 2);
        check("partial_done_count", done_cnt - d0, 1);
        check("partial_sb_left", sb_q.size(), 0);

        // Zero dimension
        resp_en = 1'b0;
        g0 = go_cnt; d0 = done_cnt;
        step();
        out_h = 8; out_w = 8; out_c = 0; start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        check("zero_busy_t1", busy, 1);
        check("zero_done_t1", done, 1);
        check("zero_go_t1", phase_go, 0);
        @(negedge clk);
        check("zero_busy_t2", busy, 0);
        check("zero_done_t2", done, 0);
        repeat (3) @(negedge clk);
        check("zero_go_count", go_cnt - g0, 0);
        check("zero_done_count", done_cnt - d0, 1);

        // Handshake robustness: 32x64x8, two tiles, manual phase units
        push(0, 0, 0, 32, 32, 8);
        push(0, 0, 32, 32, 32, 8);
        d0 = done_cnt;
        start_layer(32, 64, 8);
        @(negedge clk);
        check("hs_go_rdin", phase_go, 4'b0001);
        man_pd = 4'b0001;               // same cycle as go: must be ignored
        pulse(4'b0100);                 // inactive phase bit during RD_IN
        check("hs_ignored_done", phase_go, 0);
        check("hs_still_busy", busy, 1);
        step();
        start = 1'b1;                   // start while busy
        out_h = 1; out_w = 1; out_c = 1;
        step();
        start = 1'b0;
        @(negedge clk);
        check("hs_start_ignored_go", phase_go, 0);
        pulse(4'b0001);
        check("hs_go_rdk", phase_go, 4'b0010);
        pulse(4'b0010);
        check("hs_go_mac", phase_go, 4'b0100);
        pulse(4'b0100);
        check("hs_go_wr", phase_go, 4'b1000);
        pulse(4'b1000);
        check("hs_adv_no_go", phase_go, 0);
        @(negedge clk);
        check("hs_rdin_at_d2", phase_go, 4'b0001);
        pulse(4'b0001);
        check("hs_skip_rdk", phase_go, 4'b0100);
        pulse(4'b0100);
        check("hs_go_wr2", phase_go, 4'b1000);
        pulse(4'b1000);
        @(negedge clk);
        check("hs_done", done, 1);
        @(negedge clk);
        check("hs_idle", busy, 0);
        check("hs_done_count", done_cnt - d0, 1);
        check("hs_sb_left", sb_q.size(), 0);

        // Reset mid-layer during MAC
        push(0, 0, 0, 32, 32, 8);
        start_layer(32, 32, 8);
        @(negedge clk);
        check("rst_go_rdin", phase_go, 4'b0001);
        pulse(4'b0001);
        check("rst_go_rdk", phase_go, 4'b0010);
        pulse(4'b0010);
        check("rst_go_mac", phase_go, 4'b0100);
        d0 = done_cnt;
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        repeat (3) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_idle", busy, 0);

        push(0, 0, 0, 32, 32, 8);
        resp_en = 1'b1;
        r0 = rdk_cnt; d0 = done_cnt;
        start_layer(32, 32, 8);
        wait_done("fresh", 1000);
        check("fresh_rdk_count", rdk_cnt - r0, 1);
        check("fresh_done_count", done_cnt - d0, 1);
        check("fresh_sb_left", sb_q.size(), 0);
        resp_en = 1'b0;

        // Maximum coordinates on the 8-bit instance: out_w = 2^8-1
        for (int r = 0; r < 33; r += 32)
            for (int c = 0; c < 255; c += 32)
                push2(0, r, c, (r == 32) ? 1 : 32, (c == 224) ? 31 : 32, 8);
        step();
        b_out_h = 33; b_out_w = 255; b_out_c = 8; b_start = 1'b1;
        step();
        b_start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (b_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("maxw_timeout", 64'(seen), 1);
        repeat (2) @(negedge clk);
        check("maxw_sb_left", sb2_q.size(), 0);
        check("maxw_rdk_count", b_rdk_cnt, 1);
        check("maxw_done_count", b_done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
